// File: rtl/fetch_sequencer.sv
// fetch_sequencer: run controller for the 6-bit instruction address counter.
// Issues START_ADDR onward for a programmed number of fetches. Handles stall,
// redirect (with out-of-range redirect flagged), halt, and wrap from WRAP_MAX
// to WRAP_TO. Gives a Start/Done handshake to the top-level run control.
// Optional build macro FETCH_PERF_EN adds the StallCycles / RedirCount counters.
module fetch_sequencer #(
  parameter int AW         = 6,
  parameter int START_ADDR = 0,
  parameter int WRAP_MAX   = 61,
  parameter int WRAP_TO    = 1,
  parameter int LW         = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [LW-1:0] RunLen,
  input  logic          Stall,
  input  logic          RedirValid,
  input  logic [AW-1:0] RedirAddr,
  input  logic          HaltReq,
  output logic [AW-1:0] Addr,
  output logic          AddrValid,
  output logic          Busy,
  output logic          Done,
  output logic          BadRedir
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]   StallCycles,
  output logic [15:0]   RedirCount
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [AW-1:0] START_A = AW'(START_ADDR);
  localparam logic [AW-1:0] WMAX_A  = AW'(WRAP_MAX);
  localparam logic [AW-1:0] WTO_A   = AW'(WRAP_TO);

  logic [1:0]    state;
  logic [LW-1:0] run_len;
  logic [LW-1:0] issue_cnt;

  logic [AW-1:0] adv_addr;
  logic [AW-1:0] redir_tgt;
  logic [AW-1:0] next_addr;
  logic          redir_bad;
  logic          take_redir;
  logic          issue_now;
  logic          last_issue;

  // Next-address selection and issue detection for the current RUN cycle.
  // Halt wins over everything; a redirect overrides a stall and counts as an issue.
  always_comb begin
    adv_addr   = (Addr == WMAX_A) ? WTO_A : Addr + AW'(1);
    redir_bad  = (RedirAddr > WMAX_A);
    redir_tgt  = redir_bad ? WTO_A : RedirAddr;
    take_redir = (state == S_RUN) && !HaltReq && RedirValid;
    issue_now  = (state == S_RUN) && !HaltReq && (RedirValid || !Stall);
    next_addr  = RedirValid ? redir_tgt : adv_addr;
    last_issue = issue_now && ((issue_cnt + LW'(1)) == run_len);
  end

  // Run state machine, address register, issue counter and bad-redirect pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      Addr      <= START_A;
      run_len   <= '0;
      issue_cnt <= '0;
      BadRedir  <= 1'b0;
    end else begin
      BadRedir <= take_redir && redir_bad;
      case (state)
        S_IDLE: begin
          if (Start) begin
            run_len   <= RunLen;
            issue_cnt <= '0;
            if (RunLen != '0) begin
              state <= S_RUN;
              Addr  <= START_A;
            end else begin
              state <= S_FIN;
            end
          end
        end
        S_RUN: begin
          if (HaltReq) begin
            state <= S_FIN;
          end else if (issue_now) begin
            Addr      <= next_addr;
            issue_cnt <= issue_cnt + LW'(1);
            if (last_issue) state <= S_FIN;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status outputs are pure decodes of the run state.
  always_comb begin
    AddrValid = (state == S_RUN);
    Busy      = (state == S_RUN);
    Done      = (state == S_FIN);
  end

`ifdef FETCH_PERF_EN
  // Saturating stall-cycle and redirect counters, cleared when a run is accepted.
  always_ff @(posedge Clk) begin
    if (Reset || (state == S_IDLE && Start)) begin
      StallCycles <= '0;
      RedirCount  <= '0;
    end else begin
      if ((state == S_RUN) && Stall && !RedirValid && !HaltReq && StallCycles != 16'hFFFF)
        StallCycles <= StallCycles + 16'd1;
      if (take_redir && RedirCount != 16'hFFFF)
        RedirCount <= RedirCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus a randomized run, each checked
// against a behavioural model that tracks remaining issues and phase.
module tb_fetch_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] RunLen = '0;
  logic       Stall = 1'b0;
  logic       RedirValid = 1'b0;
  logic [5:0] RedirAddr = '0;
  logic       HaltReq = 1'b0;
  logic [5:0] Addr;
  logic       AddrValid;
  logic       Busy;
  logic       Done;
  logic       BadRedir;
`ifdef FETCH_PERF_EN
  logic [15:0] StallCycles;
  logic [15:0] RedirCount;
`endif

  int errors = 0;
  int checks = 0;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_FIN  = 2;

  // Behavioural model state.
  int mPhase;
  int mAddr;
  int mRemain;
  bit mBad;
  int mStallCyc;
  int mRedirCnt;

  fetch_sequencer dut (
`ifdef FETCH_PERF_EN
    .StallCycles(StallCycles),
    .RedirCount(RedirCount),
`endif
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .RunLen(RunLen),
    .Stall(Stall),
    .RedirValid(RedirValid),
    .RedirAddr(RedirAddr),
    .HaltReq(HaltReq),
    .Addr(Addr),
    .AddrValid(AddrValid),
    .Busy(Busy),
    .Done(Done),
    .BadRedir(BadRedir)
  );

  always #5 Clk = ~Clk;

  wire [9:0] dutVec = {Addr, AddrValid, Busy, Done, BadRedir};

  function automatic logic [9:0] modelVec();
    logic [5:0] a;
    a = mAddr[5:0];
    return {a, mPhase == P_RUN, mPhase == P_RUN, mPhase == P_FIN, mBad};
  endfunction

  // Drive one cycle of inputs, advance the model by the same rules, then
  // wait past the rising edge so outputs are settled.
  task automatic step(input bit rst, input bit st, input int rl, input bit sl,
                      input bit rv, input int ra, input bit hl);
    Reset = rst; Start = st; RunLen = rl[7:0]; Stall = sl;
    RedirValid = rv; RedirAddr = ra[5:0]; HaltReq = hl;
    mBad = 0;
    if (rst) begin
      mPhase = P_IDLE; mAddr = 0; mRemain = 0; mStallCyc = 0; mRedirCnt = 0;
    end else if (mPhase == P_IDLE) begin
      if (st) begin
        mStallCyc = 0; mRedirCnt = 0;
        if (rl != 0) begin mPhase = P_RUN; mAddr = 0; mRemain = rl; end
        else mPhase = P_FIN;
      end
    end else if (mPhase == P_RUN) begin
      if (hl) mPhase = P_FIN;
      else if (rv) begin
        if (ra > 61) begin mAddr = 1; mBad = 1; end else mAddr = ra;
        if (mRedirCnt < 65535) mRedirCnt++;
        mRemain--;
        if (mRemain == 0) mPhase = P_FIN;
      end else if (sl) begin
        if (mStallCyc < 65535) mStallCyc++;
      end else begin
        mAddr = (mAddr == 61) ? 1 : (mAddr + 1) % 64;
        mRemain--;
        if (mRemain == 0) mPhase = P_FIN;
      end
    end else begin
      mPhase = P_IDLE;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dutVec !== 10'b000000_0000) begin
      errors++;
      $display("[TB] FAIL reset_values: got %b required %b", dutVec, 10'b0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_basic();
    logic [5:0] expAddr [4] = '{6'd0, 6'd1, 6'd2, 6'd3};
    step(0, 1, 4, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (dutVec !== modelVec()) begin
        errors++;
        $display("[TB] FAIL basic_model k=%0d: got %b required %b", k, dutVec, modelVec());
      end
      if (k < 4) begin
        checks++;
        if (Addr !== expAddr[k] || AddrValid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL basic_addr k=%0d: got %0d/%b required %0d/1", k, Addr, AddrValid, expAddr[k]);
        end
      end else if (k == 4) begin
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || AddrValid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL basic_done: got D%b B%b V%b required D1 B0 V0", Done, Busy, AddrValid);
        end
      end
      step(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_wrap();
    int seen [$];
    int expSeq [$] = '{0, 59, 60, 61, 1, 2};
    step(0, 1, 6, 0, 0, 0, 0);
    if (AddrValid === 1'b1) seen.push_back(int'(Addr));
    step(0, 0, 0, 0, 1, 59, 0);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (dutVec !== modelVec()) begin
        errors++;
        $display("[TB] FAIL wrap_model k=%0d: got %b required %b", k, dutVec, modelVec());
      end
      if (AddrValid === 1'b1) seen.push_back(int'(Addr));
      step(0, 0, 0, 0, 0, 0, 0);
    end
    checks++;
    if (seen != expSeq) begin
      errors++;
      $display("[TB] FAIL wrap_sequence: got %p required %p", seen, expSeq);
    end
  endtask

  task automatic test_stall();
    step(0, 1, 5, 0, 0, 0, 0);
    idle(2);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (Addr !== 6'd2 || AddrValid !== 1'b1 || dutVec !== modelVec()) begin
        errors++;
        $display("[TB] FAIL stall_hold k=%0d: got %b required addr 2 / %b", k, dutVec, modelVec());
      end
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (StallCycles !== 16'd3) begin
      errors++;
      $display("[TB] FAIL stall_cycles: got %0d required 3", StallCycles);
    end
`endif
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (dutVec !== modelVec()) begin
        errors++;
        $display("[TB] FAIL stall_resume k=%0d: got %b required %b", k, dutVec, modelVec());
      end
    end
  endtask

  task automatic test_redir_stall();
    step(0, 1, 8, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 40, 0);
    checks++;
    if (Addr !== 6'd40 || BadRedir !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redir_over_stall: got %0d bad=%b required 40 bad=0", Addr, BadRedir);
    end
    step(0, 0, 0, 0, 1, 63, 0);
    checks++;
    if (Addr !== 6'd1 || BadRedir !== 1'b1 || dutVec !== modelVec()) begin
      errors++;
      $display("[TB] FAIL bad_redir: got %0d bad=%b required 1 bad=1", Addr, BadRedir);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (BadRedir !== 1'b0 || dutVec !== modelVec()) begin
      errors++;
      $display("[TB] FAIL bad_redir_pulse: got %b required %b", dutVec, modelVec());
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (RedirCount !== 16'd2) begin
      errors++;
      $display("[TB] FAIL redir_count: got %0d required 2", RedirCount);
    end
`endif
    step(0, 0, 0, 0, 0, 0, 1);
    idle(2);
  endtask

  task automatic test_halt();
    step(0, 1, 10, 0, 0, 0, 0);
    idle(5);
    step(0, 0, 0, 0, 1, 20, 1);
    checks++;
    if (AddrValid !== 1'b0 || Addr !== 6'd5 || Done !== 1'b1 || dutVec !== modelVec()) begin
      errors++;
      $display("[TB] FAIL halt: got addr %0d V%b D%b required addr 5 V0 D1", Addr, AddrValid, Done);
    end
    idle(1);
  endtask

  task automatic test_zero_len();
    bit sawValid = 0;
    step(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (Done !== 1'b1 || AddrValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_len_done: got D%b V%b required D1 V0", Done, AddrValid);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      if (AddrValid !== 1'b0 || Done !== 1'b0) sawValid = 1;
    end
    checks++;
    if (sawValid) begin
      errors++;
      $display("[TB] FAIL zero_len_quiet: got activity after Done required none");
    end
  endtask

  task automatic test_reset_midrun();
    bit sawDone = 0;
    step(0, 1, 20, 0, 0, 0, 0);
    idle(7);
    checks++;
    if (Addr !== 6'd7) begin
      errors++;
      $display("[TB] FAIL midrun_setup: got %0d required 7", Addr);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dutVec !== 10'b0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got %b required %b", dutVec, 10'b0);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      if (Done !== 1'b0) sawDone = 1;
    end
    checks++;
    if (sawDone) begin
      errors++;
      $display("[TB] FAIL midrun_no_done: got Done pulse required none");
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 12),
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 63),
           $urandom_range(0, 31) == 0);
      checks++;
      if (dutVec !== modelVec()) begin
        errors++;
        $display("[TB] FAIL random k=%0d: got %b required %b", k, dutVec, modelVec());
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (StallCycles !== mStallCyc[15:0] || RedirCount !== mRedirCnt[15:0]) begin
        errors++;
        $display("[TB] FAIL random_perf k=%0d: got %0d/%0d required %0d/%0d", k, StallCycles, RedirCount, mStallCyc, mRedirCnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_redir_stall();
    test_halt();
    test_zero_len();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
